// File: rtl/cgra_cfg_sequencer_if.sv
// Host/array-facing bus of the CGRA configuration sequencer.
// master = host plus PE array side, slave = sequencer side.
interface cgra_cfg_sequencer_if #(
    parameter int NUM_PE = 4,
    parameter int CFG_W  = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [CFG_W-1:0]  pe_cfg_data;
    logic [NUM_PE-1:0] pe_cfg_we;
    logic              pe_clr;
    logic              pe_en;
    logic [1:0]        res_sel;
    logic [7:0]        res_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err;

    modport master (
        output in_data, in_valid, res_data, out_ready,
        input  in_ready, pe_cfg_data, pe_cfg_we, pe_clr, pe_en, res_sel,
               out_data, out_valid, busy, err
    );

    modport slave (
        input  in_data, in_valid, res_data, out_ready,
        output in_ready, pe_cfg_data, pe_cfg_we, pe_clr, pe_en, res_sel,
               out_data, out_valid, busy, err
    );
endinterface

// File: rtl/cgra_cfg_sequencer.sv
// Byte-stream command sequencer for a 2x2 CGRA: loads PE configs, runs the
// array for N cycles and returns a selected PE result to the host.
module cgra_cfg_sequencer #(
    parameter int NUM_PE = 4,
    parameter int CFG_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cgra_cfg_sequencer_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, CFG_LO, CFG_HI, CFG_WR, RUN_LEN, CLR, RUN, RD_SEL, RD_OUT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_CFG = 4'h1, OP_RUN = 4'h2,
                           OP_READ = 4'h3, OP_CLRERR = 4'h4;

    state_t     state, state_d;
    logic [1:0] pe_idx;
    logic [7:0] cnt;
    logic       accept;
    logic [3:0] opcode;

    assign opcode        = bus.in_data[7:4];
    assign bus.in_ready  = (state == IDLE) || (state == CFG_LO) ||
                           (state == CFG_HI) || (state == RUN_LEN);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.pe_clr    = (state == CLR);
    assign bus.pe_en     = (state == RUN);
    // Strobe decoded from state, so a reset can never leave a write pending.
    assign bus.pe_cfg_we = (state == CFG_WR) ? (NUM_PE'(1) << pe_idx) : '0;

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) begin
                case (opcode)
                    OP_CFG:  state_d = CFG_LO;
                    OP_RUN:  state_d = RUN_LEN;
                    OP_READ: state_d = RD_SEL;
                    default: state_d = IDLE;
                endcase
            end
            CFG_LO:  if (accept) state_d = CFG_HI;
            CFG_HI:  if (accept) state_d = CFG_WR;
            CFG_WR:  state_d = IDLE;
            RUN_LEN: if (accept) state_d = CLR;
            CLR:     state_d = (cnt != 8'd0) ? RUN : IDLE;
            RUN:     if (cnt <= 8'd1) state_d = IDLE;
            RD_SEL:  state_d = RD_OUT;
            RD_OUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pe_idx          <= 2'd0;
            cnt             <= 8'd0;
            bus.pe_cfg_data <= '0;
            bus.res_sel     <= 2'd0;
            bus.out_data    <= 8'd0;
            bus.out_valid   <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                case (state)
                    IDLE: begin
                        case (opcode)
                            OP_NOP, OP_RUN: ;
                            OP_CFG:    pe_idx      <= bus.in_data[1:0];
                            OP_READ:   bus.res_sel <= bus.in_data[1:0];
                            OP_CLRERR: bus.err     <= 1'b0;
                            default:   bus.err     <= 1'b1;
                        endcase
                    end
                    CFG_LO:  bus.pe_cfg_data[7:0]  <= bus.in_data;
                    CFG_HI:  bus.pe_cfg_data[15:8] <= bus.in_data;
                    RUN_LEN: cnt                   <= bus.in_data;
                    default: ;
                endcase
            end
            if (state == RUN) cnt <= cnt - 8'd1;
            // RD_SEL gives the array one cycle to settle on the new res_sel.
            if (state == RD_SEL) begin
                bus.out_data  <= bus.res_data;
                bus.out_valid <= 1'b1;
            end
            if (state == RD_OUT && bus.out_ready) bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/cgra_cfg_sequencer.md
CGRA_CFG_SEQUENCER -- requirements
Module: cgra_cfg_sequencer

Interface
REQ-001 Parameter: NUM_PE, 4, number of PEs in the 2x2 array (fixed 4; index 2 bits).
REQ-002 Parameter: CFG_W, 16, per-PE configuration word width (loaded as 2 bytes).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  command/operand byte stream.
REQ-006 in_valid  input  1  in_data valid; byte accepted when in_valid & in_ready on a rising edge.
REQ-007 in_ready  output  1  sequencer can accept a byte this cycle.
REQ-008 pe_cfg_data  output  16  configuration word for PE being written.
REQ-009 pe_cfg_we  output  4  one-hot PE config write strobe.
REQ-010 pe_clr  output  1  one-cycle clear of all PE accumulators/registers.
REQ-011 pe_en  output  1  array run enable (PEs step when high).
REQ-012 res_sel  output  2  PE index whose result drives res_data.
REQ-013 res_data  input  8  result byte of PE selected by res_sel (combinational from array).
REQ-014 out_data  output  8  result byte to host.
REQ-015 out_valid  output  1  out_data valid; held until out_valid & out_ready.
REQ-016 out_ready  input  1  host accepts out_data.
REQ-017 busy  output  1  high whenever state != IDLE.
REQ-018 err  output  1  sticky illegal-opcode flag.

Function
REQ-019 Command byte in IDLE: opcode = in_data[7:4], arg = in_data[1:0]; opcodes 0x0 NOP, 0x1 CFG, 0x2 RUN, 0x3 READ, 0x4 CLRERR.
REQ-020 States: IDLE, CFG_LO, CFG_HI, CFG_WR, RUN_LEN, CLR, RUN, RD_SEL, RD_OUT.
REQ-021 in_ready = 1 only in IDLE, CFG_LO, CFG_HI, RUN_LEN; 0 in all other states.
REQ-022 NOP: accepted, no output change, stay IDLE.
REQ-023 CFG: latch arg as PE index, IDLE->CFG_LO; accepted byte -> pe_cfg_data[7:0], ->CFG_HI; accepted byte -> pe_cfg_data[15:8], ->CFG_WR.
REQ-024 CFG_WR: pe_cfg_we = (1 << index) for exactly one cycle, pe_cfg_data stable that cycle, ->IDLE.
REQ-025 pe_cfg_data holds last written value outside CFG loads; pe_cfg_we = 0 in every state except CFG_WR.
REQ-026 RUN: IDLE->RUN_LEN; accepted byte N latched into 8-bit down-counter, ->CLR.
REQ-027 CLR: pe_clr = 1 for exactly one cycle; ->RUN if N != 0, else ->IDLE.
REQ-028 RUN: pe_en = 1 for exactly N consecutive cycles (N = 1..255), counter decrements each cycle, ->IDLE after the cycle where count reaches 1; pe_en = 0 in all other states.
REQ-029 READ: res_sel <= arg, ->RD_SEL; RD_SEL waits one cycle for res_data to settle, then out_data <= res_data, out_valid <= 1, ->RD_OUT.
REQ-030 RD_OUT: out_valid and out_data held stable until out_ready = 1; on handshake out_valid <= 0 same edge, ->IDLE; out_ready while out_valid = 0 has no effect.
REQ-031 res_sel holds last READ index until next READ.
REQ-032 CLRERR: err <= 0, stay IDLE.
REQ-033 Opcodes 0x5-0xF in IDLE: byte consumed, err <= 1, stay IDLE, no other output change.
REQ-034 in_valid while in_ready = 0: no byte consumed, no state effect; host must hold byte.
REQ-035 Operand bytes (CFG_LO, CFG_HI, RUN_LEN) are never decoded as opcodes; any value legal.
REQ-036 Minimum latencies: CFG command-to-strobe 3 accepted bytes + 1 cycle; RUN N: byte accept -> pe_clr next cycle -> pe_en next N cycles; READ accept -> out_valid after 2 cycles.

Reset
REQ-037 rst = 1 on a rising edge: state <= IDLE, pe_cfg_data <= 0, pe_cfg_we <= 0, pe_clr <= 0, pe_en <= 0, res_sel <= 0, out_data <= 0, out_valid <= 0, err <= 0, counter <= 0; busy = 0, in_ready = 1 in cycle after reset release.
REQ-038 Reset mid-operation (any state, incl. RUN with pe_en high or RD_OUT with out_valid high) aborts immediately; pe_en/out_valid low the cycle after reset asserts, no pending write strobe issued.

Verification
REQ-039 Bytes 0x12, 0xCD, 0xAB -> exactly one cycle pe_cfg_we = 4'b0100 with pe_cfg_data = 0xABCD; busy low next cycle.
REQ-040 Bytes 0x20, 0x05 -> one pe_clr pulse, then pe_en high exactly 5 cycles; 0x20, 0x00 -> pe_clr pulse, zero pe_en cycles, back to IDLE.
REQ-041 Byte 0x33 with res_data = 0x5A, out_ready held 0 for 4 cycles -> res_sel = 3, out_valid = 1 with out_data = 0x5A stable 4 cycles, drops the cycle after out_ready = 1.
REQ-042 Byte 0x70 -> err = 1, state IDLE; then 0x40 -> err = 0; in_valid held high during RUN -> no bytes consumed until IDLE.
REQ-043 rst asserted on 3rd cycle of RUN N = 10 -> pe_en low next cycle, all outputs at REQ-037 values, subsequent CFG completes normally.
